// File: rtl/core_sequencer.sv
// Control sequencer for the mini-core IF -> LD -> EX pipeline: program load, PC generation,
// RAW hazard bubbles, multiplier freeze and halt drain.
module core_sequencer #(
   parameter int unsigned IADDR_W = 5,
   parameter int unsigned DADDR_W = 6,
   parameter int unsigned INST_W  = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_valid,
   input  logic [INST_W-1:0]  load_inst,
   input  logic               start,
   input  logic [INST_W-1:0]  fetch_inst,
   input  logic               alu_done,
   output logic               inst_wr_en,
   output logic [IADDR_W-1:0] inst_wr_addr,
   output logic [INST_W-1:0]  inst_wr_data,
   output logic [IADDR_W-1:0] inst_rd_addr,
   output logic               freeze,
   output logic               if_hold,
   output logic               bubble,
   output logic               halted,
   output logic               busy,
   output logic [IADDR_W:0]   prog_len
);

   localparam logic [1:0]       OP_MUL  = 2'd2;
   localparam logic [1:0]       OP_HALT = 2'd3;
   localparam logic [IADDR_W:0] FULL    = {1'b1, {IADDR_W{1'b0}}};
   localparam logic [IADDR_W:0] ONE     = {{IADDR_W{1'b0}}, 1'b1};

   typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StHalted} state_e;

   state_e               state_q, state_d;
   logic [IADDR_W:0]     prog_len_q, prog_len_d;
   logic [IADDR_W:0]     pc_q, pc_d;
   logic                 if_v_q, if_v_d;
   logic                 ld_v_q, ld_v_d;
   logic [1:0]           ld_op_q, ld_op_d;
   logic [DADDR_W-1:0]   ld_dst_q, ld_dst_d;
   logic                 ex_v_q, ex_v_d;
   logic [DADDR_W-1:0]   ex_dst_q, ex_dst_d;

   logic [1:0]           f_op;
   logic [DADDR_W-1:0]   f_src1, f_src2, f_dst;
   logic                 mul_wait, hazard, src_hit_ld, src_hit_ex;

   assign f_op   = fetch_inst[INST_W-1 -: 2];
   assign f_src1 = fetch_inst[3*DADDR_W-1 -: DADDR_W];
   assign f_src2 = fetch_inst[2*DADDR_W-1 -: DADDR_W];
   assign f_dst  = fetch_inst[DADDR_W-1:0];

   assign src_hit_ld = ld_v_q && (f_src1 == ld_dst_q || f_src2 == ld_dst_q);
   assign src_hit_ex = ex_v_q && (f_src1 == ex_dst_q || f_src2 == ex_dst_q);
   assign mul_wait   = ld_v_q && (ld_op_q == OP_MUL) && !alu_done;
   assign hazard     = if_v_q && (f_op != OP_HALT) && (src_hit_ld || src_hit_ex);

   assign inst_wr_data = load_inst;
   assign inst_rd_addr = pc_q[IADDR_W-1:0];
   assign prog_len     = prog_len_q;
   assign halted       = (state_q == StHalted);
   assign busy         = (state_q == StRun) || (state_q == StDrain);

   always_comb begin
      state_d      = state_q;
      prog_len_d   = prog_len_q;
      pc_d         = pc_q;
      if_v_d       = if_v_q;
      ld_v_d       = ld_v_q;
      ld_op_d      = ld_op_q;
      ld_dst_d     = ld_dst_q;
      ex_v_d       = ex_v_q;
      ex_dst_d     = ex_dst_q;
      inst_wr_en   = 1'b0;
      inst_wr_addr = '0;
      freeze       = 1'b0;
      if_hold      = 1'b0;
      bubble       = 1'b0;

      unique case (state_q)
         StIdle, StHalted: begin
            if (load_valid) begin
               inst_wr_en = 1'b1;
               prog_len_d = ONE;
               state_d    = StLoad;
            end else if (start && prog_len_q != '0) begin
               pc_d    = '0;
               if_v_d  = 1'b0;
               ld_v_d  = 1'b0;
               ex_v_d  = 1'b0;
               state_d = StRun;
            end
         end
         StLoad: begin
            // The write pointer always equals the number of words loaded so far.
            inst_wr_addr = prog_len_q[IADDR_W-1:0];
            if (load_valid) begin
               if (prog_len_q != FULL) begin
                  inst_wr_en = 1'b1;
                  prog_len_d = prog_len_q + ONE;
               end
            end else if (start) begin
               pc_d    = '0;
               if_v_d  = 1'b0;
               ld_v_d  = 1'b0;
               ex_v_d  = 1'b0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (mul_wait) begin
               freeze = 1'b1;
            end else begin
               ex_v_d   = ld_v_q;
               ex_dst_d = ld_dst_q;
               if (if_v_q && f_op == OP_HALT) begin
                  if_v_d  = 1'b0;
                  ld_v_d  = 1'b0;
                  state_d = StDrain;
               end else if (hazard) begin
                  if_hold = 1'b1;
                  bubble  = 1'b1;
                  ld_v_d  = 1'b0;
               end else begin
                  ld_v_d   = if_v_q;
                  ld_op_d  = f_op;
                  ld_dst_d = f_dst;
                  if (pc_q == prog_len_q) begin
                     // Implicit end: the last word still moves into LD, nothing new is fetched.
                     if_v_d  = 1'b0;
                     state_d = StDrain;
                  end else begin
                     if_v_d = 1'b1;
                     pc_d   = pc_q + ONE;
                  end
               end
            end
         end
         StDrain: begin
            if (mul_wait) begin
               freeze = 1'b1;
            end else begin
               ex_v_d   = ld_v_q;
               ex_dst_d = ld_dst_q;
               ld_v_d   = 1'b0;
               // Leave on the edge at which LD and EX both become empty.
               if (!ld_v_q) state_d = StHalted;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         prog_len_q <= '0;
         pc_q       <= '0;
         if_v_q     <= 1'b0;
         ld_v_q     <= 1'b0;
         ld_op_q    <= '0;
         ld_dst_q   <= '0;
         ex_v_q     <= 1'b0;
         ex_dst_q   <= '0;
      end else begin
         state_q    <= state_d;
         prog_len_q <= prog_len_d;
         pc_q       <= pc_d;
         if_v_q     <= if_v_d;
         ld_v_q     <= ld_v_d;
         ld_op_q    <= ld_op_d;
         ld_dst_q   <= ld_dst_d;
         ex_v_q     <= ex_v_d;
         ex_dst_q   <= ex_dst_d;
      end
   end

endmodule
